sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: BASE_ADDR, default 1024, byte address mapped to SRAM line 0.
REQ-002 Parameter: WAIT_CYCLES, default 5, SRAM cycles per read or write phase (range 1-15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  write request from memory stage; held stable until ready.
REQ-006 rd_en  input  1  read request from memory stage; held stable until ready.
REQ-007 address  input  32  byte address (ALU result).
REQ-008 wdata  input  32  store data (Val_Rm).
REQ-009 rdata  output  32  load data, registered.
REQ-010 ready  output  1  low freezes pipeline; high means no access pending or access complete.
REQ-011 SRAM_DQ  inout  64  SRAM data bus.
REQ-012 SRAM_ADDR  output  17  SRAM 64-bit line address.
REQ-013 SRAM_WE_N  output  1  SRAM write enable, active-low.

Function
REQ-014 Offset = address - BASE_ADDR (32-bit wrap); line = offset[19:3]; half = offset[2]; offset[1:0] ignored.
REQ-015 FSM states: IDLE, RD, WR_RD, WR, DONE; 4-bit phase counter cnt.
REQ-016 IDLE: wr_en -> WR_RD; else rd_en -> RD; else stay; line/half/wdata latched on leaving IDLE.
REQ-017 wr_en and rd_en both high: write priority.
REQ-018 RD and WR_RD: SRAM_WE_N=1, DQ high-Z, WAIT_CYCLES cycles; DQ sampled into 64-bit line register on last cycle.
REQ-019 RD exits to DONE; WR_RD exits to WR with merged line (half=0 replaces [31:0], half=1 replaces [63:32]).
REQ-020 WR: SRAM_WE_N=0, DQ driven with merged line, WAIT_CYCLES cycles, then DONE.
REQ-021 SRAM_DQ driven only in WR; high-Z in all other states and during reset.
REQ-022 SRAM_ADDR = latched line in all states.
REQ-023 DONE: one cycle, ready=1, then IDLE; rdata updated on RD exit (half=0 -> [31:0], half=1 -> [63:32]), unchanged by writes.
REQ-024 ready = 1 in DONE, or in IDLE when wr_en=rd_en=0; else 0.
REQ-025 Latency (request seen in IDLE at cycle 0): read ready at cycle WAIT_CYCLES+1; write at cycle 2*WAIT_CYCLES+1.
REQ-026 Request dropped mid-access: access completes regardless; DONE then IDLE.

Reset
REQ-027 rst high: FSM=IDLE, cnt=0, rdata=0, latched line/half/wdata=0, SRAM_ADDR=0, SRAM_WE_N=1, DQ high-Z, buffer invalid; immediate, including mid-WR.
REQ-028 First cycle after reset release: ready follows REQ-024.

Configuration
REQ-029 Macro SRAM_READ_BUF_EN defined: one-line read buffer (64-bit data, 17-bit tag, valid bit).
REQ-030 Buffer, macro defined: read in IDLE with valid tag match -> DONE next cycle (ready at cycle 1), no SRAM access; every RD/WR_RD fill loads buffer; WR completion writes merged line into buffer on tag match.
REQ-031 Macro undefined: no buffer logic; every read takes REQ-025 latency.

Verification (BASE_ADDR=1024, WAIT_CYCLES=5)
REQ-032 Write 0xDEADBEEF @1024 -> ready low cycles 0-10, SRAM_WE_N low 5 cycles, SRAM_ADDR=0, DQ[31:0]=0xDEADBEEF; then read @1024 -> rdata=0xDEADBEEF, ready at cycle 6.
REQ-033 SRAM line 0 = 0x11111111_22222222, write 0xAAAAAAAA @1028 -> line 0 = 0xAAAAAAAA_22222222.
REQ-034 wr_en=rd_en=1, address 1032, wdata 0x5 -> WR_RD/WR sequence, SRAM_ADDR=1, write latency 11.
REQ-035 rst pulsed during WR cycle 2 -> same cycle SRAM_WE_N=1, DQ high-Z; after release with no request ready=1, rdata=0.
REQ-036 Read @1032 then @1036 -> second ready at cycle 1 with SRAM_READ_BUF_EN, cycle 6 without; both rdata match SRAM.
REQ-037 Read @1024+2^20 -> SRAM_ADDR=0 (wrap).

Source files
------------

// File: rtl/sram_controller.sv
// Memory-stage bridge from a 32-bit load/store port to a 64-bit async SRAM.
// Optional one-line read buffer is enabled by defining SRAM_READ_BUF_EN.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    inout  wire  [63:0] SRAM_DQ,
    output logic [16:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);

    typedef enum logic [2:0] {IDLE, RD, WR_RD, WR, DONE} state_t;

    state_t      state;
    state_t      next;
    logic [3:0]  cnt;
    logic [16:0] line_q;
    logic        half_q;
    logic [31:0] wdata_q;
    logic [63:0] line_buf;
    logic [19:0] offset;
    logic [63:0] merged;
    logic        last;
    logic        start;
    logic        hit;
    logic        unused;

    // Only offset bits [19:2] select line/half, so 20-bit math is enough.
    assign offset = address[19:0] - BASE_ADDR[19:0];
    assign unused = ^{address[31:20], offset[1:0]};

    assign last  = (cnt == WAIT_CYCLES[3:0] - 4'd1);
    assign start = (state == IDLE) && (wr_en || rd_en);

    assign merged = half_q ? {wdata_q, SRAM_DQ[31:0]}
                           : {SRAM_DQ[63:32], wdata_q};

    assign SRAM_ADDR = line_q;
    assign SRAM_WE_N = (state != WR);
    assign SRAM_DQ   = (state == WR) ? line_buf : 64'bz;

`ifdef SRAM_READ_BUF_EN
    logic [63:0] buf_data;
    logic [16:0] buf_tag;
    logic        buf_valid;

    assign hit = buf_valid && (buf_tag == offset[19:3]);

    // Read buffer: filled by every SRAM read phase, kept coherent on writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data  <= '0;
            buf_tag   <= '0;
            buf_valid <= 1'b0;
        end else if ((state == RD || state == WR_RD) && last) begin
            buf_data  <= SRAM_DQ;
            buf_tag   <= line_q;
            buf_valid <= 1'b1;
        end else if (state == WR && last && buf_valid
                     && buf_tag == line_q) begin
            buf_data <= line_buf;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Next-state and handshake decode.
    always_comb begin
        next  = state;
        ready = 1'b0;
        unique case (state)
            IDLE: begin
                ready = !wr_en && !rd_en;
                if (wr_en)      next = WR_RD;
                else if (rd_en) next = hit ? DONE : RD;
            end
            RD:    if (last) next = DONE;
            WR_RD: if (last) next = WR;
            WR:    if (last) next = DONE;
            DONE: begin
                ready = 1'b1;
                next  = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // State register and phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next;
            if ((state == RD || state == WR_RD || state == WR) && !last)
                cnt <= cnt + 4'd1;
            else
                cnt <= '0;
        end
    end

    // Request latch, line register and load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q   <= '0;
            half_q   <= 1'b0;
            wdata_q  <= '0;
            line_buf <= '0;
            rdata    <= '0;
        end else begin
            if (start) begin
                line_q  <= offset[19:3];
                half_q  <= offset[2];
                wdata_q <= wdata;
            end
`ifdef SRAM_READ_BUF_EN
            if (start && !wr_en && hit)
                rdata <= offset[2] ? buf_data[63:32] : buf_data[31:0];
`endif
            if (state == RD && last) begin
                line_buf <= SRAM_DQ;
                rdata    <= half_q ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
            end
            if (state == WR_RD && last)
                line_buf <= merged;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small 8-line SRAM model.
// Read latency expectations depend on SRAM_READ_BUF_EN.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    wire  [63:0] SRAM_DQ;
    logic [16:0] SRAM_ADDR;
    logic        SRAM_WE_N;

`ifdef SRAM_READ_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(5)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .address(address),
        .wdata(wdata),
        .rdata(rdata),
        .ready(ready),
        .SRAM_DQ(SRAM_DQ),
        .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [8];
    logic        init_mem = 1'b1;
    int          we_cnt = 0;

    assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[2:0]] : 64'bz;

    // SRAM model: preload once, then capture every write cycle.
    always @(posedge clk) begin
        if (init_mem) begin
            mem[0] <= 64'h11111111_22222222;
            mem[1] <= 64'h33333333_44444444;
            mem[2] <= 64'h0;
            mem[3] <= 64'h0;
            mem[4] <= 64'h0;
            mem[5] <= 64'h0;
            mem[6] <= 64'h0;
            mem[7] <= 64'h77777777_88888888;
        end else if (!SRAM_WE_N) begin
            mem[SRAM_ADDR[2:0]] <= SRAM_DQ;
            we_cnt <= we_cnt + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic access(input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        address = a;
        wdata = d;
        #1;
        lat = 0;
        while (!ready && lat < 60) begin
            @(negedge clk);
            #1;
            lat++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic [16:0] exp_addr;
        bit          hit;
        logic [63:0] exp_line;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat;
        int w0;
        int exp_lat;

        vecs[0] = '{1, 0, 32'd1028, 32'hAAAAAAAA, 32'h0,
                    17'd0, 0, 64'hAAAAAAAA_22222222};
        vecs[1] = '{0, 1, 32'd1024, 32'h0, 32'h22222222,
                    17'd0, 1, 64'h0};
        vecs[2] = '{1, 0, 32'd1024, 32'hDEADBEEF, 32'h22222222,
                    17'd0, 0, 64'hAAAAAAAA_DEADBEEF};
        vecs[3] = '{0, 1, 32'd1024, 32'h0, 32'hDEADBEEF,
                    17'd0, 1, 64'h0};
        vecs[4] = '{0, 1, 32'd1032, 32'h0, 32'h44444444,
                    17'd1, 0, 64'h0};
        vecs[5] = '{0, 1, 32'd1036, 32'h0, 32'h33333333,
                    17'd1, 1, 64'h0};
        vecs[6] = '{0, 1, 32'd1049600, 32'h0, 32'hDEADBEEF,
                    17'd0, 0, 64'h0};
        vecs[7] = '{1, 1, 32'd1032, 32'h5, 32'hDEADBEEF,
                    17'd1, 0, 64'h33333333_00000005};
        vecs[8] = '{0, 1, 32'd1036, 32'h0, 32'h33333333,
                    17'd1, 1, 64'h0};
        vecs[9] = '{0, 1, 32'd1016, 32'h0, 32'h88888888,
                    17'h1FFFF, 0, 64'h0};

        @(posedge clk);
        @(negedge clk);
        init_mem = 1'b0;
        #1;
        check("rst ready", {63'd0, ready}, 64'd1);
        check("rst rdata", {32'd0, rdata}, 64'd0);
        check("rst addr", {47'd0, SRAM_ADDR}, 64'd0);
        check("rst we_n", {63'd0, SRAM_WE_N}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst ready", {63'd0, ready}, 64'd1);

        for (int i = 0; i < 10; i++) begin
            w0 = we_cnt;
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd, lat);
            if (vecs[i].wr)
                exp_lat = 11;
            else
                exp_lat = (BUF && vecs[i].hit) ? 1 : 6;
            check($sformatf("v%0d latency", i), 64'(lat), 64'(exp_lat));
            check($sformatf("v%0d rdata", i), {32'd0, rdata},
                  {32'd0, vecs[i].exp_rdata});
            check($sformatf("v%0d sram_addr", i), {47'd0, SRAM_ADDR},
                  {47'd0, vecs[i].exp_addr});
            check($sformatf("v%0d we cycles", i), 64'(we_cnt - w0),
                  vecs[i].wr ? 64'd5 : 64'd0);
            if (vecs[i].wr) begin
                @(negedge clk);
                check($sformatf("v%0d sram line", i),
                      mem[vecs[i].exp_addr[2:0]], vecs[i].exp_line);
            end
        end

        // Reset in the middle of a write phase.
        @(negedge clk);
        wr_en = 1'b1;
        address = 32'd1028;
        wdata = 32'h00000099;
        lat = 0;
        while (SRAM_WE_N && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("mid-wr reached WR", {63'd0, SRAM_WE_N}, 64'd0);
        check("mid-wr dq", SRAM_DQ, 64'h00000099_DEADBEEF);
        @(negedge clk);
        rst = 1'b1;
        wr_en = 1'b0;
        #1;
        check("async rst we_n", {63'd0, SRAM_WE_N}, 64'd1);
        check("async rst addr", {47'd0, SRAM_ADDR}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after rst ready", {63'd0, ready}, 64'd1);
        check("after rst rdata", {32'd0, rdata}, 64'd0);

        // Buffer must be invalid after reset: full-latency read.
        access(1'b0, 1'b1, 32'd1028, 32'h0, lat);
        check("post-rst read lat", 64'(lat), 64'd6);
        check("post-rst read data", {32'd0, rdata}, 64'h00000099);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
